// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    RESP
  } state_e;

  localparam int unsigned WORD_BYTES = 8;
  localparam int unsigned ADDR_MAX_W = 64;
  localparam int unsigned ADDR_EXT_W = ADDR_MAX_W + 1;

  // Last byte of the quadword must land inside the array; the extra bit keeps the carry of addr+7.
  function automatic logic range_ok(input logic [ADDR_MAX_W-1:0] addr,
                                    input logic [ADDR_MAX_W-1:0] mem_bytes);
    logic [ADDR_EXT_W-1:0] last;
    last = {1'b0, addr} + ADDR_EXT_W'(WORD_BYTES - 1);
    return last < {1'b0, mem_bytes};
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Single-port byte array: synchronous write, combinational read.
module dmem_byte_ram #(
  parameter int unsigned MEM_BYTES = 2048,
  parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [7:0]    wdata_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem [MEM_BYTES];

  always_ff @(posedge clk) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: serves 64-bit little-endian loads/stores one byte per cycle.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 2048,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [63:0]       resp_rdata,
  output logic              resp_err
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  state_e            state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic [63:0]       rdata_q, rdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [AW-1:0]     ram_addr;
  logic [7:0]        ram_wdata;
  logic [7:0]        ram_rdata;
  logic              ram_we;

  assign ram_addr  = AW'(addr_q + ADDR_W'(cnt_q));
  assign ram_wdata = wdata_q[{cnt_q, 3'b000} +: 8];
  assign ram_we    = (state_q == XFER) && write_q && !err_q && !reset;

  dmem_byte_ram #(
    .MEM_BYTES (MEM_BYTES)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = !range_ok(ADDR_MAX_W'(req_addr), ADDR_MAX_W'(MEM_BYTES));
          state_d = XFER;
        end
      end
      XFER: begin
        // Out-of-range requests spend a single access-free XFER cycle so the
        // error response appears one cycle after acceptance.
        if (err_q) begin
          state_d = RESP;
        end else begin
          if (!write_q) rdata_d[{cnt_q, 3'b000} +: 8] = ram_rdata;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic against a transaction-level model.
module tb_dmem_responder;

  localparam int unsigned MEM_BYTES = 2048;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_chk  = 0;
  int n_pass = 0;

  dmem_responder #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: got timeout expected event", nm);
  endtask

  // Transaction-level model: an accepted request occupies the block for
  // 8 cycles (1 if out of range) then waits for the response handshake.
  logic [7:0]  mm [MEM_BYTES];
  bit          m_idle  = 1'b1;
  bit          m_valid = 1'b0;
  int          m_wait  = 0;
  bit          m_w, m_err;
  logic [63:0] m_a, m_d, m_rdata;

  always @(posedge clk) begin
    if (reset) begin
      m_idle = 1'b1; m_valid = 1'b0; m_wait = 0;
    end else if (m_idle) begin
      if (req_valid) begin
        m_idle  = 1'b0;
        m_w     = req_write;
        m_a     = req_addr;
        m_d     = req_wdata;
        m_err   = !(req_addr <= 64'(MEM_BYTES - 8));
        m_wait  = m_err ? 1 : 8;
        m_rdata = '0;
        if (!m_err && !m_w)
          for (int i = 0; i < 8; i++) m_rdata[8*i +: 8] = mm[int'(m_a) + i];
      end
    end else if (m_wait > 0) begin
      if (!m_err && m_w) mm[int'(m_a) + 8 - m_wait] = m_d[8*(8 - m_wait) +: 8];
      m_wait--;
      if (m_wait == 0) m_valid = 1'b1;
    end else if (m_valid && resp_ready) begin
      m_valid = 1'b0; m_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, m_idle);
    chk("resp_valid", resp_valid, m_valid);
    if (m_valid) begin
      chk("resp_rdata", resp_rdata, m_rdata);
      chk("resp_err", resp_err, m_err);
    end
  end

  task automatic wait_resp(output logic [63:0] rd, output logic e, output int lat);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
    if (lat >= 40) fail_now("resp_timeout");
    rd = resp_rdata; e = resp_err;
  endtask

  task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                      output logic [63:0] rd, output logic e, output int lat, output int acc);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    if (n >= 40) fail_now("accept_timeout");
    @(posedge clk);
    acc = int'($time / 10);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(rd, e, lat);
  endtask

  logic [63:0] rd, r0;
  logic        e, e0;
  int          lat, acc;
  int          accs [4];
  bit          saw_resp;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_rdata", resp_rdata, 64'h0);
    chk("rst_err", resp_err, 1'b0);
    reset = 1'b0;

    xact(1'b1, 64'd16, 64'h0102030405060708, rd, e, lat, acc);
    chk("st16_err", e, 1'b0);
    chk("st16_lat", lat, 8);
    chk("st16_mem16", dut.u_ram.mem[16], 8'h08);
    chk("st16_mem23", dut.u_ram.mem[23], 8'h01);
    xact(1'b0, 64'd16, 64'h0, rd, e, lat, acc);
    chk("ld16_data", rd, 64'h0102030405060708);
    chk("ld16_err", e, 1'b0);
    chk("ld16_lat", lat, 8);

    xact(1'b1, 64'd0, 64'hAAAAAAAAAAAAAAAA, rd, e, lat, acc);
    xact(1'b1, 64'd3, 64'h1122334455667788, rd, e, lat, acc);
    xact(1'b0, 64'd0, 64'h0, rd, e, lat, acc);
    chk("ld0_data", rd, 64'h4455667788AAAAAA);
    xact(1'b0, 64'd3, 64'h0, rd, e, lat, acc);
    chk("ld3_data", rd, 64'h1122334455667788);

    xact(1'b1, 64'd2040, 64'hDEADBEEFCAFEF00D, rd, e, lat, acc);
    xact(1'b0, 64'd2040, 64'h0, rd, e, lat, acc);
    chk("ld2040_err", e, 1'b0);
    chk("ld2040_data", rd, 64'hDEADBEEFCAFEF00D);
    xact(1'b0, 64'd2041, 64'h0, rd, e, lat, acc);
    chk("ld2041_err", e, 1'b1);
    chk("ld2041_data", rd, 64'h0);
    chk("ld2041_lat", lat, 1);
    xact(1'b1, 64'hFFFFFFFFFFFFFFFC, 64'h5555555555555555, rd, e, lat, acc);
    chk("stwrap_err", e, 1'b1);
    chk("stwrap_lat", lat, 1);
    chk("stwrap_mem0", dut.u_ram.mem[0], 8'hAA);
    chk("stwrap_mem3", dut.u_ram.mem[3], 8'h88);
    chk("stwrap_mem2044", dut.u_ram.mem[2044], 8'hEF);
    chk("stwrap_mem2047", dut.u_ram.mem[2047], 8'hDE);

    // Backpressure with a second request held during RESP.
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd3;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(r0, e0, lat);
    chk("bp_data", r0, 64'h1122334455667788);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd16;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", resp_valid, 1'b1);
      chk("bp_rdata_hold", resp_rdata, r0);
      chk("bp_err_hold", resp_err, e0);
      chk("bp_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_idle_ready", req_ready, 1'b1);
    chk("bp_idle_valid", resp_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_held_accepted", req_ready, 1'b0);
    wait_resp(rd, e, lat);
    chk("bp_held_data", rd, 64'h0102030405060708);
    chk("bp_held_lat", lat, 8);

    // Reset in the middle of a store: first three bytes land, the rest do not.
    xact(1'b1, 64'd32, 64'h0, rd, e, lat, acc);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd32; req_wdata = '1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_req_ready", req_ready, 1'b1);
    chk("abort_resp_valid", resp_valid, 1'b0);
    for (int i = 32; i < 40; i++)
      chk("abort_mem", dut.u_ram.mem[i], (i < 35) ? 8'hFF : 8'h00);
    saw_resp = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (resp_valid === 1'b1) saw_resp = 1'b1;
    end
    chk("abort_no_resp", saw_resp, 1'b0);

    // Back-to-back with resp_ready high.
    xact(1'b0, 64'd16, 64'h0, rd, e, lat, accs[0]);
    chk("b2b_0", rd, 64'h0102030405060708);
    xact(1'b0, 64'd3, 64'h0, rd, e, lat, accs[1]);
    chk("b2b_1", rd, 64'h1122334455667788);
    xact(1'b0, 64'd2040, 64'h0, rd, e, lat, accs[2]);
    chk("b2b_2", rd, 64'hDEADBEEFCAFEF00D);
    xact(1'b0, 64'd32, 64'h0, rd, e, lat, accs[3]);
    chk("b2b_3", rd, 64'h0000000000FFFFFF);
    for (int i = 0; i < 3; i++) chk("b2b_spacing", accs[i+1] - accs[i], 10);

    // Random traffic over an initialised window plus occasional bad addresses.
    for (int i = 0; i < 16; i++)
      xact(1'b1, 64'(8 * i), {$urandom, $urandom}, rd, e, lat, acc);
    for (int i = 0; i < 60; i++) begin
      logic [63:0] a;
      case ($urandom_range(0, 9))
        0: a = 64'($urandom_range(2041, 2047));
        1: a = {32'hFFFFFFFF, $urandom};
        default: a = 64'($urandom_range(0, 120));
      endcase
      xact(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, rd, e, lat, acc);
      chk("rnd_lat", lat, (a <= 64'(MEM_BYTES - 8)) ? 8 : 1);
      if ($urandom_range(0, 2) == 0) begin
        resp_ready = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        resp_ready = 1'b1;
      end
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
